// File: rtl/psx_pad_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : psx_pad_pkg                                                  |
// | Description : Shared constants, state encoding, frame snapshot type and   |
// |               tx byte selection for the PSX pad emulator.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package psx_pad_pkg;

   // Host command bytes and pad response bytes
   localparam logic [7:0] CMD_START  = 8'h01;
   localparam logic [7:0] CMD_POLL   = 8'h42;
   localparam logic [7:0] ID_DIGITAL = 8'h41;
   localparam logic [7:0] ID_ANALOG  = 8'h73;
   localparam logic [7:0] PAD_READY  = 8'h5A;

   // Frame lengths in bytes
   localparam int FRAME_DIG = 5;
   localparam int FRAME_ANA = 9;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SHIFT     = 3'd1,
      ST_ACK_WAIT  = 3'd2,
      ST_ACK_PULSE = 3'd3,
      ST_HOLD      = 3'd4
   } pad_state_e;

   // Pad inputs frozen at the start of a frame
   typedef struct packed {
      logic        analog;
      logic [15:0] buttons;
      logic [31:0] sticks;
   } pad_snap_t;

   // Byte the pad returns at a given position of the frame
   function automatic logic [7:0] tx_byte_sel(input logic [3:0] idx, input pad_snap_t snap);
      logic [7:0] b;
      b = 8'hFF;
      case (idx)
         4'd0:    b = 8'hFF;
         4'd1:    b = snap.analog ? ID_ANALOG : ID_DIGITAL;
         4'd2:    b = PAD_READY;
         4'd3:    b = snap.buttons[7:0];
         4'd4:    b = snap.buttons[15:8];
         4'd5:    b = snap.sticks[7:0];
         4'd6:    b = snap.sticks[15:8];
         4'd7:    b = snap.sticks[23:16];
         4'd8:    b = snap.sticks[31:24];
         default: b = 8'hFF;
      endcase
      return b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/psx_pad_emulator_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : psx_sync_edge                                                |
// | Description : Two-flop synchroniser for an asynchronous bus pin with       |
// |               single-cycle rise and fall pulses on the synchronised level. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module psx_sync_edge
   import psx_pad_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic async_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   // Pin chain resets to the idle-high bus level so reset never creates an edge
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign level_o = sync_q;
   assign rise_o  = sync_q & ~prev_q;
   assign fall_o  = ~sync_q & prev_q;

endmodule
`default_nettype wire

// File: rtl/psx_pad_emulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : psx_pad_emulator                                             |
// | Description : PlayStation pad emulator answering host polls in digital    |
// |               (0x41) or analog (0x73) mode with programmable ACK timing.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module psx_pad_emulator
   import psx_pad_pkg::*;
#(
   parameter int unsigned CLK_PER_US = 16,
   parameter int unsigned ACK_DELAY  = 48,
   parameter int unsigned ACK_WIDTH  = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        psx_clk,
   input  logic        att,
   input  logic        cmd,
   input  logic        analog_mode,
   input  logic [15:0] buttons,
   input  logic [31:0] sticks,
   output logic        data,
   output logic        ack,
   output logic        busy,
   output logic        poll_done
);

   // One counter serves both the ACK delay and the ACK width phases
   localparam int unsigned CNT_MAX = (ACK_DELAY > ACK_WIDTH) ? ACK_DELAY : ACK_WIDTH;
   localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
   localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(ACK_DELAY - 1);
   localparam logic [CNT_W-1:0] WIDTH_LAST = CNT_W'(ACK_WIDTH - 1);
   localparam logic [3:0] LAST_DIG = 4'(FRAME_DIG - 1);
   localparam logic [3:0] LAST_ANA = 4'(FRAME_ANA - 1);

   if (ACK_DELAY < 1 || ACK_WIDTH < 1 || CLK_PER_US < 1) begin : g_param_check
      $error("psx_pad_emulator: ACK_DELAY, ACK_WIDTH and CLK_PER_US must be >= 1");
   end

   logic psx_lvl, psx_rise, psx_fall;
   logic att_lvl, att_rise, att_fall;
   logic cmd_lvl, cmd_rise, cmd_fall;
   logic unused_edges;

   psx_sync_edge u_sync_psx_clk (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_i (psx_clk),
      .level_o (psx_lvl),
      .rise_o  (psx_rise),
      .fall_o  (psx_fall)
   );

   psx_sync_edge u_sync_att (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_i (att),
      .level_o (att_lvl),
      .rise_o  (att_rise),
      .fall_o  (att_fall)
   );

   // Only the level of cmd matters; it is sampled on psx_clk rises
   psx_sync_edge u_sync_cmd (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_i (cmd),
      .level_o (cmd_lvl),
      .rise_o  (cmd_rise),
      .fall_o  (cmd_fall)
   );

   assign unused_edges = ^{psx_lvl, att_lvl, cmd_rise, cmd_fall};

   pad_state_e       state_q, state_d;
   logic [3:0]       byte_q, byte_d;
   logic [2:0]       bit_q, bit_d;
   logic [6:0]       rx_q, rx_d;      // bits received so far; the 8th arrives live
   logic [CNT_W-1:0] cnt_q, cnt_d;
   pad_snap_t        snap_q, snap_d;
   logic             data_q, data_d;
   logic             ack_q, ack_d;
   logic             done_q, done_d;

   logic [7:0] tx_byte;
   logic [7:0] rx_byte;
   logic [3:0] last_idx;

   assign tx_byte  = tx_byte_sel(byte_q, snap_q);
   assign rx_byte  = {cmd_lvl, rx_q};
   assign last_idx = snap_q.analog ? LAST_ANA : LAST_DIG;

   // Frame sequencing: bit shifting, byte evaluation and ACK timing
   always_comb begin
      state_d = state_q;
      byte_d  = byte_q;
      bit_d   = bit_q;
      rx_d    = rx_q;
      cnt_d   = cnt_q;
      snap_d  = snap_q;
      data_d  = data_q;
      ack_d   = 1'b1;
      done_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            data_d = 1'b1;
            if (att_fall) begin
               state_d        = ST_SHIFT;
               snap_d.analog  = analog_mode;
               snap_d.buttons = buttons;
               snap_d.sticks  = sticks;
               byte_d         = 4'd0;
               bit_d          = 3'd0;
               rx_d           = 7'd0;
            end
         end

         ST_SHIFT: begin
            if (psx_fall) begin
               data_d = tx_byte[bit_q];
            end
            if (psx_rise) begin
               rx_d  = rx_byte[7:1];
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  if ((byte_q == 4'd0 && rx_byte != CMD_START) ||
                      (byte_q == 4'd1 && rx_byte != CMD_POLL)) begin
                     // Not addressed to us, or not a poll: stay silent
                     state_d = ST_HOLD;
                     data_d  = 1'b1;
                  end else if (byte_q == last_idx) begin
                     state_d = ST_HOLD;
                     data_d  = 1'b1;
                     done_d  = 1'b1;
                  end else begin
                     state_d = ST_ACK_WAIT;
                     byte_d  = byte_q + 4'd1;
                     cnt_d   = '0;
                  end
               end
            end
         end

         ST_ACK_WAIT: begin
            if (psx_fall) begin
               // Host did not wait for ACK: this fall is bit 0 of the next byte
               state_d = ST_SHIFT;
               data_d  = tx_byte[bit_q];
            end else if (cnt_q == DELAY_LAST) begin
               state_d = ST_ACK_PULSE;
               cnt_d   = '0;
               ack_d   = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_ACK_PULSE: begin
            if (psx_fall) begin
               state_d = ST_SHIFT;
               data_d  = tx_byte[bit_q];
            end else if (cnt_q == WIDTH_LAST) begin
               state_d = ST_SHIFT;
            end else begin
               cnt_d = cnt_q + 1'b1;
               ack_d = 1'b0;
            end
         end

         ST_HOLD: begin
            data_d = 1'b1;
         end

         default: begin
            state_d = ST_IDLE;
            data_d  = 1'b1;
         end
      endcase

      // Deselect wins over everything, including a same-cycle clock edge
      if (att_rise) begin
         state_d = ST_IDLE;
         data_d  = 1'b1;
         ack_d   = 1'b1;
         done_d  = 1'b0;
      end
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         byte_q  <= 4'd0;
         bit_q   <= 3'd0;
         rx_q    <= 7'd0;
         cnt_q   <= '0;
         snap_q  <= '0;
         data_q  <= 1'b1;
         ack_q   <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         byte_q  <= byte_d;
         bit_q   <= bit_d;
         rx_q    <= rx_d;
         cnt_q   <= cnt_d;
         snap_q  <= snap_d;
         data_q  <= data_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
      end
   end

   assign data      = data_q;
   assign ack       = ack_q;
   assign busy      = (state_q != ST_IDLE);
   assign poll_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_psx_pad_emulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_psx_pad_emulator                                          |
// | Description : Self-checking bench: host-side bus driver, frame reference  |
// |               model and ACK / poll_done timing monitor.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_psx_pad_emulator;

   localparam int ACK_DELAY = 48;
   localparam int ACK_WIDTH = 32;
   localparam int HALF      = 32;   // 250 kHz host clock at 16 clk/us

   typedef logic [7:0] frame_t [9];

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        psx_clk = 1'b1;
   logic        att = 1'b1;
   logic        cmd = 1'b1;
   logic        analog_mode = 1'b0;
   logic [15:0] buttons = 16'hFFFF;
   logic [31:0] sticks = 32'h0;
   logic        data, ack, busy, poll_done;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int last_rise = 0;
   int ack_falls = 0;
   int done_pulses = 0;
   bit skip_width = 1'b0;

   psx_pad_emulator #(
      .CLK_PER_US (16),
      .ACK_DELAY  (ACK_DELAY),
      .ACK_WIDTH  (ACK_WIDTH)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .psx_clk     (psx_clk),
      .att         (att),
      .cmd         (cmd),
      .analog_mode (analog_mode),
      .buttons     (buttons),
      .sticks      (sticks),
      .data        (data),
      .ack         (ack),
      .busy        (busy),
      .poll_done   (poll_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Timing monitor: ACK delay/width and poll_done latency/width
   logic ack_prev = 1'b1;
   logic done_prev = 1'b0;
   int   ack_start = 0;
   always @(negedge clk) begin
      if (ack_prev === 1'b1 && ack === 1'b0) begin
         ack_falls++;
         ack_start = cyc;
         check_val("ack_delay", cyc - last_rise, ACK_DELAY + 3);
      end
      if (ack_prev === 1'b0 && ack === 1'b1 && !skip_width)
         check_val("ack_width", cyc - ack_start, ACK_WIDTH);
      if (done_prev === 1'b0 && poll_done === 1'b1) begin
         done_pulses++;
         check_val("done_latency", cyc - last_rise, 3);
      end
      if (done_prev === 1'b1)
         check_val("done_width", poll_done, 1'b0);
      ack_prev  = ack;
      done_prev = poll_done;
   end

   // Reference model: what the host should read and which bytes get ACK
   function automatic void model(input logic an, input logic [15:0] btn, input logic [31:0] st,
                                 input frame_t cmds, input int nb, output frame_t exp,
                                 output logic [8:0] ackmask, output int n_ack, output int n_done);
      logic [7:0] resp [$];
      int  n;
      bit  live;
      resp = {8'hFF, (an ? 8'h73 : 8'h41), 8'h5A, btn[7:0], btn[15:8]};
      if (an) resp = {resp, st[7:0], st[15:8], st[23:16], st[31:24]};
      n = resp.size();
      live = 1'b1;
      ackmask = '0;
      n_ack = 0;
      n_done = 0;
      for (int b = 0; b < 9; b++) begin
         exp[b] = (live && b < n) ? resp[b] : 8'hFF;
         if (b < nb && live) begin
            if (b == 0 && cmds[0] != 8'h01) live = 1'b0;
            else if (b == 1 && cmds[1] != 8'h42) live = 1'b0;
            else if (b == n - 1) begin n_done++; live = 1'b0; end
            else begin ackmask[b] = 1'b1; n_ack++; end
         end
      end
   endfunction

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Host shifts one byte LSB first and samples data just before each rise
   task automatic xfer_byte(input logic [7:0] c, input int nbits, output logic [7:0] d);
      d = 8'hFF;
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         psx_clk = 1'b0;
         cmd = c[i];
         wait_cyc(HALF);
         d[i] = data;
         psx_clk = 1'b1;
         last_rise = cyc;
         if (i != 7) wait_cyc(HALF);
      end
   endtask

   task automatic wait_ack_pulse();
      int t;
      t = 0;
      while (ack !== 1'b0 && t < 400) begin @(negedge clk); t++; end
      while (ack !== 1'b1 && t < 400) begin @(negedge clk); t++; end
      check_val("ack_timeout", (t >= 400), 1'b0);
   endtask

   task automatic host_frame(input frame_t cmds, input int nb, input logic [8:0] ackmask,
                             input int early_idx, input logic chg, input logic [15:0] new_btn,
                             output frame_t got);
      logic [7:0] g;
      for (int b = 0; b < 9; b++) got[b] = 8'hFF;
      @(negedge clk);
      att = 1'b0;
      wait_cyc(20);
      for (int b = 0; b < nb; b++) begin
         xfer_byte(cmds[b], 8, g);
         got[b] = g;
         if (b == 1 && chg) buttons = new_btn;
         if (b == nb - 1) wait_cyc(20);
         else if (b + 1 == early_idx) wait_cyc(10);
         else if (ackmask[b]) begin wait_ack_pulse(); wait_cyc(10); end
         else wait_cyc(120);
      end
      @(negedge clk);
      att = 1'b1;
      wait_cyc(10);
   endtask

   task automatic run_and_check(input string tag, input logic an, input logic [15:0] btn,
                                input logic [31:0] st, input frame_t cmds, input int early_idx,
                                input logic chg, input logic [15:0] new_btn);
      frame_t     exp, got;
      logic [8:0] ackmask;
      int         n_ack, n_done, a0, d0, nb;
      nb = an ? 9 : 5;
      @(negedge clk);
      analog_mode = an;
      buttons = btn;
      sticks = st;
      model(an, btn, st, cmds, nb, exp, ackmask, n_ack, n_done);
      if (early_idx > 0 && ackmask[early_idx-1]) begin
         ackmask[early_idx-1] = 1'b0;
         n_ack--;
      end
      a0 = ack_falls;
      d0 = done_pulses;
      host_frame(cmds, nb, ackmask, early_idx, chg, new_btn, got);
      for (int b = 0; b < nb; b++)
         check_val($sformatf("%s_byte%0d", tag, b), got[b], exp[b]);
      check_val({tag, "_acks"}, ack_falls - a0, n_ack);
      check_val({tag, "_done"}, done_pulses - d0, n_done);
      check_val({tag, "_busy"}, busy, 1'b0);
   endtask

   function automatic frame_t mk_cmds(input logic [7:0] c0, input logic [7:0] c1, input bit rnd);
      frame_t f;
      for (int i = 0; i < 9; i++) f[i] = rnd ? 8'($urandom) : 8'h00;
      f[0] = c0;
      f[1] = c1;
      return f;
   endfunction

   initial begin
      #950000;
      n_checks++;
      n_errors++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      frame_t     f, exp;
      logic [7:0] g;
      logic [8:0] am;
      logic [15:0] b;
      int         na, nd, d0, c0;
      logic       an;

      // Reset state
      wait_cyc(5);
      check_val("rst_data", data, 1'b1);
      check_val("rst_ack", ack, 1'b1);
      check_val("rst_busy", busy, 1'b0);
      check_val("rst_done", poll_done, 1'b0);
      rst_n = 1'b1;
      wait_cyc(5);

      run_and_check("digital", 1'b0, 16'hFFFE, 32'h0, mk_cmds(8'h01, 8'h42, 1'b0), 0, 1'b0, 16'h0);
      run_and_check("analog", 1'b1, 16'($urandom), 32'h80807F10, mk_cmds(8'h01, 8'h42, 1'b0), 0, 1'b0, 16'h0);
      run_and_check("wrong_addr", 1'b0, 16'h1234, 32'h0, mk_cmds(8'h81, 8'h42, 1'b0), 0, 1'b0, 16'h0);

      // Abort after 3 bits of byte 3
      b = 16'($urandom);
      @(negedge clk);
      analog_mode = 1'b0;
      buttons = b;
      f = mk_cmds(8'h01, 8'h42, 1'b0);
      model(1'b0, b, 32'h0, f, 5, exp, am, na, nd);
      d0 = done_pulses;
      att = 1'b0;
      wait_cyc(20);
      for (int i = 0; i < 3; i++) begin
         xfer_byte(f[i], 8, g);
         check_val($sformatf("abort_byte%0d", i), g, exp[i]);
         wait_ack_pulse();
         wait_cyc(10);
      end
      xfer_byte(f[3], 3, g);
      wait_cyc(5);
      att = 1'b1;
      c0 = cyc;
      wait_cyc(2);
      check_val("abort_busy_pre", busy, 1'b1);
      wait_cyc(1);
      check_val("abort_lat", cyc - c0, 3);
      check_val("abort_busy", busy, 1'b0);
      check_val("abort_data", data, 1'b1);
      check_val("abort_ack", ack, 1'b1);
      check_val("abort_done", done_pulses - d0, 0);
      wait_cyc(10);
      run_and_check("after_abort", 1'b0, 16'($urandom), 32'h0, mk_cmds(8'h01, 8'h42, 1'b1), 0, 1'b0, 16'h0);

      // Early host clock on byte 2, then buttons changing mid-frame
      run_and_check("early", 1'b0, 16'($urandom), 32'h0, mk_cmds(8'h01, 8'h42, 1'b0), 2, 1'b0, 16'h0);
      b = 16'($urandom);
      run_and_check("snapshot", 1'b1, b, 32'($urandom), mk_cmds(8'h01, 8'h42, 1'b1), 0, 1'b1, ~b);

      // Synchronous reset during ACK_PULSE
      @(negedge clk);
      analog_mode = 1'b0;
      att = 1'b0;
      wait_cyc(20);
      xfer_byte(8'h01, 8, g);
      c0 = 0;
      while (ack !== 1'b0 && c0 < 400) begin @(negedge clk); c0++; end
      wait_cyc(5);
      check_val("rstmid_ack_low", ack, 1'b0);
      skip_width = 1'b1;
      rst_n = 1'b0;
      att = 1'b1;
      psx_clk = 1'b1;
      @(negedge clk);
      check_val("rstmid_ack", ack, 1'b1);
      check_val("rstmid_data", data, 1'b1);
      check_val("rstmid_busy", busy, 1'b0);
      check_val("rstmid_done", poll_done, 1'b0);
      rst_n = 1'b1;
      wait_cyc(10);
      skip_width = 1'b0;

      // Randomized frames, occasionally with a bad address or command
      for (int r = 0; r < 5; r++) begin
         an = 1'($urandom);
         f = mk_cmds(($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h01,
                     ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h42, 1'b1);
         run_and_check($sformatf("rand%0d", r), an, 16'($urandom), 32'($urandom), f, 0, 1'b0, 16'h0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
